game_controller: RTL and testbench

//   Top-level round sequencer for the memory-tile game. Generates the 9-tile

---
 rtl/game_if.sv | 28 ++
 rtl/game_controller.sv | 134 +++++++++++++
 tb/tb_game_controller.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_if.sv
// Signal bundle between the round sequencer (master) and the board / player block / display (slave).
interface game_if #(
   parameter int unsigned MAX_LEN = 9
);
   logic                     start;
   logic                     keys_idle;
   logic                     player_input;
   logic                     check;
   logic [2*MAX_LEN-1:0]     seq;
   logic [5:0]               seq_counter;
   logic                     playerEN;
   logic                     checkEN;
   logic                     show_valid;
   logic [1:0]               show_tile;
   logic [3:0]               round_len;
   logic                     win;
   logic                     lose;

   modport master (
      input  start, keys_idle, player_input, check,
      output seq, seq_counter, playerEN, checkEN, show_valid, show_tile, round_len, win, lose
   );

   modport slave (
      output start, keys_idle, player_input, check,
      input  seq, seq_counter, playerEN, checkEN, show_valid, show_tile, round_len, win, lose
   );
endinterface

// File: rtl/game_controller.sv
// Memory-tile game round sequencer: pattern generation, tile playback, per-tile player check
// and win/lose decision.
module game_controller #(
   parameter int unsigned MAX_LEN     = 9,
   parameter int unsigned SHOW_CYCLES = 25000000,
   parameter int unsigned GAP_CYCLES  = 12500000,
   parameter int unsigned CW          = 25
) (
   input logic    clk,
   input logic    resetn,
   game_if.master game
);
   localparam int unsigned SeqW = 2 * MAX_LEN;

   typedef enum logic [3:0] {
      StIdle, StShowOn, StShowOff, StRel, StWaitIn, StCheck, StJudge, StWin, StLose
   } state_e;

   state_e          r_state, w_state_d;
   logic [SeqW-1:0] r_seq, w_seq_d;
   logic [5:0]      r_seq_counter, w_seq_counter_d;
   logic [3:0]      r_round_len, w_round_len_d;
   logic [CW-1:0]   r_timer, w_timer_d;
   logic [17:0]     r_lfsr;
   logic            w_last;
   logic            w_show_done;
   logic            w_gap_done;
   logic [1:0]      w_show_tile;

   assign w_last      = (r_seq_counter == ({2'b00, r_round_len} - 6'd1));
   assign w_show_done = (r_timer == CW'(SHOW_CYCLES - 1));
   assign w_gap_done  = (r_timer == CW'(GAP_CYCLES - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= StIdle;
         r_seq         <= '0;
         r_seq_counter <= '0;
         r_round_len   <= '0;
         r_timer       <= '0;
         r_lfsr        <= 18'h2A5F3;
      end else begin
         r_state       <= w_state_d;
         r_seq         <= w_seq_d;
         r_seq_counter <= w_seq_counter_d;
         r_round_len   <= w_round_len_d;
         r_timer       <= w_timer_d;
         // Taps 18 and 11; a nonzero seed can never reach zero
         r_lfsr        <= {r_lfsr[16:0], r_lfsr[17] ^ r_lfsr[10]};
      end
   end

   always_comb begin
      w_state_d       = r_state;
      w_seq_d         = r_seq;
      w_seq_counter_d = r_seq_counter;
      w_round_len_d   = r_round_len;
      w_timer_d       = r_timer;
      case (r_state)
         StIdle, StWin, StLose: begin
            if (game.start) begin
               w_seq_d         = SeqW'(r_lfsr);
               w_round_len_d   = 4'd1;
               w_seq_counter_d = '0;
               w_timer_d       = '0;
               w_state_d       = StShowOn;
            end
         end
         StShowOn: begin
            if (w_show_done) begin
               w_timer_d = '0;
               w_state_d = StShowOff;
            end else begin
               w_timer_d = r_timer + 1'b1;
            end
         end
         StShowOff: begin
            if (w_gap_done) begin
               w_timer_d = '0;
               if (w_last) begin
                  w_seq_counter_d = '0;
                  w_state_d       = StRel;
               end else begin
                  w_seq_counter_d = r_seq_counter + 6'd1;
                  w_state_d       = StShowOn;
               end
            end else begin
               w_timer_d = r_timer + 1'b1;
            end
         end
         StRel: begin
            if (game.keys_idle) w_state_d = StWaitIn;
         end
         StWaitIn: begin
            if (game.player_input) w_state_d = StCheck;
         end
         StCheck: w_state_d = StJudge;
         StJudge: begin
            // check was registered by the player block on the CHECK edge
            if (!game.check) begin
               w_state_d = StLose;
            end else if (!w_last) begin
               w_seq_counter_d = r_seq_counter + 6'd1;
               w_state_d       = StRel;
            end else if (r_round_len == 4'(MAX_LEN)) begin
               w_state_d = StWin;
            end else begin
               w_round_len_d   = r_round_len + 4'd1;
               w_seq_counter_d = '0;
               w_timer_d       = '0;
               w_state_d       = StShowOn;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_comb begin
      w_show_tile = 2'b00;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
         if (r_seq_counter == 6'(i)) w_show_tile = {r_seq[2*i], r_seq[2*i+1]};
      end
   end

   assign game.seq         = r_seq;
   assign game.seq_counter = r_seq_counter;
   assign game.round_len   = r_round_len;
   assign game.show_tile   = w_show_tile;
   assign game.show_valid  = (r_state == StShowOn);
   assign game.playerEN    = (r_state == StWaitIn);
   assign game.checkEN     = (r_state == StCheck);
   assign game.win         = (r_state == StWin);
   assign game.lose        = (r_state == StLose);
endmodule

// File: tb/tb_game_controller.sv
// Randomised games against a reference game model; a scoreboard monitor checks playback,
// checks and outcomes as the controller presents them.
module tb_game_controller;
   localparam int unsigned MAX_LEN = 9;
   localparam int unsigned SHOW    = 4;
   localparam int unsigned GAP     = 2;

   logic clk = 1'b0;
   logic resetn;

   game_if #(.MAX_LEN(MAX_LEN)) gif ();

   game_controller #(
      .MAX_LEN(MAX_LEN), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .CW(3)
   ) dut (
      .clk(clk), .resetn(resetn), .game(gif)
   );

   always #5 clk = ~clk;

   typedef struct {logic [17:0] seq; int k; int rl; logic [1:0] tile;} show_t;
   typedef struct {logic [17:0] seq; int k; int rl;} chk_t;

   show_t show_q[$];
   chk_t  chk_q[$];
   int    out_q[$];   // 1 = win, 2 = lose

   int n_cmp = 0;
   int n_bad = 0;

   // Pattern generator as described: 18-bit Fibonacci, taps 18 and 11, steps every clock
   logic [17:0] m_lfsr;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) m_lfsr <= 18'h2A5F3;
      else         m_lfsr <= {m_lfsr[16:0], m_lfsr[18-1] ^ m_lfsr[11-1]};
   end

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic flag(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s at %0t", nm, $time);
   endtask

   function automatic logic [1:0] tile_of(input logic [17:0] s, input int k);
      return {s[2*k], s[2*k+1]};
   endfunction

   // Monitor: pops expectations whenever the controller presents an event
   initial begin : monitor
      logic p_sv, p_ce, p_w, p_l;
      int   lit, dark;
      show_t es;
      chk_t  ec;
      int    eo;
      p_sv = 0; p_ce = 0; p_w = 0; p_l = 0; lit = 0; dark = 0;
      forever begin
         @(negedge clk);
         if (resetn !== 1'b1) begin
            p_sv = 0; p_ce = 0; p_w = 0; p_l = 0; lit = 0; dark = 0;
            continue;
         end
         if (gif.show_valid && !p_sv) begin
            if (show_q.size() == 0) flag("unexpected show_valid");
            else begin
               es = show_q.pop_front();
               cmp("show_k", 32'(gif.seq_counter), es.k);
               cmp("show_tile", 32'(gif.show_tile), 32'(es.tile));
               cmp("show_round_len", 32'(gif.round_len), es.rl);
               cmp("show_seq", 32'(gif.seq), 32'(es.seq));
               if (es.k > 0) cmp("show_gap", dark, GAP);
            end
            lit = 0;
         end
         if (gif.show_valid) lit++;
         if (!gif.show_valid && p_sv) begin
            cmp("show_len", lit, SHOW);
            dark = 0;
         end
         if (!gif.show_valid) dark++;
         if (gif.checkEN) begin
            cmp("checken_single", 32'(p_ce), 0);
            cmp("en_exclusive", 32'(gif.playerEN), 0);
            if (!p_ce) begin
               if (chk_q.size() == 0) flag("unexpected checkEN");
               else begin
                  ec = chk_q.pop_front();
                  cmp("check_k", 32'(gif.seq_counter), ec.k);
                  cmp("check_round_len", 32'(gif.round_len), ec.rl);
                  cmp("check_seq", 32'(gif.seq), 32'(ec.seq));
               end
            end
         end
         if ((gif.win && !p_w) || (gif.lose && !p_l)) begin
            if (out_q.size() == 0) flag("unexpected outcome");
            else begin
               eo = out_q.pop_front();
               cmp("outcome", {30'd0, gif.lose, gif.win}, eo);
               cmp("outcome_playerEN", 32'(gif.playerEN), 0);
               if (eo == 1) cmp("win_round_len", 32'(gif.round_len), MAX_LEN);
            end
         end
         if (gif.round_len > 4'(MAX_LEN)) flag("round_len above MAX_LEN");
         p_sv = gif.show_valid; p_ce = gif.checkEN; p_w = gif.win; p_l = gif.lose;
      end
   end

   task automatic wait_for_pen(output bit ok);
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (gif.playerEN) begin
            ok = 1;
            break;
         end
      end
      if (!ok) flag("timeout waiting for playerEN");
   endtask

   task automatic wait_outcome();
      bit seen = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (gif.win || gif.lose) begin
            seen = 1;
            break;
         end
      end
      if (!seen) flag("timeout waiting for win/lose");
   endtask

   // Called at a negedge; fail_r == 0 plays a perfect game
   task automatic play_game(input int fail_r, input int fail_k, input int long_hold_r);
      logic [17:0] s;
      bit ok, done, bad;
      int h;
      s = m_lfsr;
      done = 0;
      for (int r = 1; r <= int'(MAX_LEN) && !done; r++) begin
         for (int k = 0; k < r; k++) show_q.push_back('{s, k, r, tile_of(s, k)});
         for (int k = 0; k < r && !done; k++) begin
            chk_q.push_back('{s, k, r});
            if (r == fail_r && k == fail_k) begin
               out_q.push_back(2);
               done = 1;
            end
         end
      end
      if (!done) out_q.push_back(1);

      gif.start = 1'b1;
      @(negedge clk);
      gif.start = 1'b0;
      cmp("start_show_valid", 32'(gif.show_valid), 1);
      cmp("start_round_len", 32'(gif.round_len), 1);

      for (int r = 1; r <= int'(MAX_LEN); r++) begin
         for (int k = 0; k < r; k++) begin
            wait_for_pen(ok);
            if (!ok) return;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            gif.player_input = 1'b1;
            @(negedge clk);
            bad = (r == fail_r && k == fail_k);
            gif.check     = !bad;
            gif.keys_idle = 1'b0;
            h = (r == long_hold_r && k == 0) ? 21 : $urandom_range(2, 5);
            for (int j = 0; j < h; j++) begin
               @(negedge clk);
               if (j == 0) gif.player_input = 1'b0;
               cmp("rel_hold_playerEN", 32'(gif.playerEN), 0);
            end
            gif.keys_idle = 1'b1;
            if (bad) begin
               wait_outcome();
               return;
            end
            if (k < r - 1) begin
               @(negedge clk);
               cmp("rel_release_playerEN", 32'(gif.playerEN), 1);
            end
         end
      end
      wait_outcome();
   endtask

   task automatic check_reset_outputs();
      cmp("rst_seq", 32'(gif.seq), 0);
      cmp("rst_seq_counter", 32'(gif.seq_counter), 0);
      cmp("rst_round_len", 32'(gif.round_len), 0);
      cmp("rst_show_valid", 32'(gif.show_valid), 0);
      cmp("rst_show_tile", 32'(gif.show_tile), 0);
      cmp("rst_playerEN", 32'(gif.playerEN), 0);
      cmp("rst_checkEN", 32'(gif.checkEN), 0);
      cmp("rst_win", 32'(gif.win), 0);
      cmp("rst_lose", 32'(gif.lose), 0);
   endtask

   // Starts a game, then resets in SHOW_ON (in_wait=0) or WAIT_IN (in_wait=1)
   task automatic reset_mid(input bit in_wait);
      logic [17:0] s;
      bit ok;
      s = m_lfsr;
      show_q.push_back('{s, 0, 1, tile_of(s, 0)});
      gif.start = 1'b1;
      @(negedge clk);
      gif.start = 1'b0;
      if (in_wait) begin
         wait_for_pen(ok);
         if (!ok) return;
      end
      cmp("pre_reset_active", 32'(in_wait ? gif.playerEN : gif.show_valid), 1);
      #2 resetn = 1'b0;
      #1 check_reset_outputs();
      show_q.delete();
      chk_q.delete();
      out_q.delete();
      repeat (2) @(negedge clk);
      #2 resetn = 1'b1;
      repeat (2) @(negedge clk);
      cmp("post_reset_idle_len", 32'(gif.round_len), 0);
      cmp("post_reset_idle_show", 32'(gif.show_valid), 0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      int fr, fk;
      gif.start = 1'b0;
      gif.keys_idle = 1'b1;
      gif.player_input = 1'b0;
      gif.check = 1'b0;
      resetn = 1'b1;
      #1 resetn = 1'b0;
      #2 check_reset_outputs();
      repeat (3) @(negedge clk);
      #2 resetn = 1'b1;
      @(negedge clk);

      play_game(0, 0, 3);
      play_game(3, 1, 0);
      for (int g = 0; g < 3; g++) begin
         fr = $urandom_range(0, MAX_LEN);
         fk = (fr > 0) ? $urandom_range(0, fr - 1) : 0;
         play_game(fr, fk, 0);
      end
      reset_mid(1'b0);
      reset_mid(1'b1);
      fr = $urandom_range(1, MAX_LEN);
      play_game(fr, $urandom_range(0, fr - 1), 0);

      repeat (3) @(negedge clk);
      cmp("show_queue_drained", show_q.size(), 0);
      cmp("check_queue_drained", chk_q.size(), 0);
      cmp("outcome_queue_drained", out_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
